// File: rtl/m_of_n_checker.sv
// m_of_n_checker: serial M-of-N frame checker with resync, registered results and saturating error count
module m_of_n_checker #(
   parameter int N     = 5,
   parameter int M     = 2,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in,
   input  logic             in_valid,
   input  logic             sync,
   input  logic             clear_cnt,
   output logic             frame_done,
   output logic             code_ok,
   output logic             code_err,
   output logic [N-1:0]     word,
   output logic [ERR_W-1:0] err_count
);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(N + 1);

   logic [IW-1:0] bit_idx;
   logic [CW-1:0] ones, ones_nxt;
   logic [N-1:0]  shreg, sh_nxt;
   logic          last, fin, ok_nxt;

   // next-frame values for an accepted bit and end-of-frame detection
   always_comb begin
      sh_nxt   = {in, shreg[N-1:1]};
      ones_nxt = ones + CW'(in);
      last     = bit_idx == IW'(N - 1);
      fin      = in_valid & ~sync & last;
      ok_nxt   = ones_nxt == CW'(M);
   end

   // frame assembly; sync discards any partial frame and may seed the new one
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bit_idx <= '0;
         ones    <= '0;
         shreg   <= '0;
      end else if (sync) begin
         bit_idx <= in_valid ? IW'(1) : '0;
         ones    <= in_valid ? CW'(in) : '0;
         if (in_valid) shreg <= {in, {(N-1){1'b0}}};
      end else if (in_valid) begin
         shreg   <= sh_nxt;
         bit_idx <= last ? '0 : bit_idx + IW'(1);
         ones    <= last ? '0 : ones_nxt;
      end
   end

   // registered frame results, held until the next completed frame
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_done <= 1'b0;
         code_ok    <= 1'b0;
         code_err   <= 1'b0;
         word       <= '0;
      end else begin
         frame_done <= fin;
         if (fin) begin
            word     <= sh_nxt;
            code_ok  <= ok_nxt;
            code_err <= ~ok_nxt;
         end
      end
   end

   // saturating error counter; clear wins over a same-cycle error
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) err_count <= '0;
      else if (clear_cnt) err_count <= '0;
      else if (fin && !ok_nxt && !(&err_count)) err_count <= err_count + ERR_W'(1);
   end
endmodule

// File: tb/tb_m_of_n_checker.sv
// tb_m_of_n_checker: scoreboard bench for three checker configurations
module tb_m_of_n_checker;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;
   logic in_a, v_a, s_a, c_a, in_b, v_b, s_b, c_b, in_c, v_c, s_c, c_c;
   logic fd_a, ok_a, er_a, fd_b, ok_b, er_b, fd_c, ok_c, er_c;
   logic [4:0] w_a, w_b;
   logic [7:0] w_c, e_a, e_c;
   logic [1:0] e_b;

   typedef struct {
      logic [31:0] w;
      logic        ok;
      int          ec;
   } exp_t;
   exp_t qa[$], qb[$], qc[$];
   int errors = 0;
   int checks = 0;

   m_of_n_checker #(.N(5), .M(2), .ERR_W(8)) dut_a (.clk(clk), .rstn(rstn), .in(in_a), .in_valid(v_a), .sync(s_a), .clear_cnt(c_a),
      .frame_done(fd_a), .code_ok(ok_a), .code_err(er_a), .word(w_a), .err_count(e_a));
   m_of_n_checker #(.N(5), .M(2), .ERR_W(2)) dut_b (.clk(clk), .rstn(rstn), .in(in_b), .in_valid(v_b), .sync(s_b), .clear_cnt(c_b),
      .frame_done(fd_b), .code_ok(ok_b), .code_err(er_b), .word(w_b), .err_count(e_b));
   m_of_n_checker #(.N(8), .M(4), .ERR_W(8)) dut_c (.clk(clk), .rstn(rstn), .in(in_c), .in_valid(v_c), .sync(s_c), .clear_cnt(c_c),
      .frame_done(fd_c), .code_ok(ok_c), .code_err(er_c), .word(w_c), .err_count(e_c));

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic unexpected(string n);
      checks++;
      errors++;
      $display("FAIL %s: frame_done pulse with no expected frame", n);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (fd_a === 1'b1) begin
         if (qa.size() == 0) unexpected("a_frame");
         else begin
            e = qa.pop_front();
            chk("a_word", 32'(w_a), e.w);
            chk("a_ok", 32'(ok_a), 32'(e.ok));
            chk("a_err", 32'(er_a), 32'(!e.ok));
            chk("a_cnt", 32'(e_a), e.ec);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (fd_b === 1'b1) begin
         if (qb.size() == 0) unexpected("b_frame");
         else begin
            e = qb.pop_front();
            chk("b_word", 32'(w_b), e.w);
            chk("b_ok", 32'(ok_b), 32'(e.ok));
            chk("b_err", 32'(er_b), 32'(!e.ok));
            chk("b_cnt", 32'(e_b), e.ec);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (fd_c === 1'b1) begin
         if (qc.size() == 0) unexpected("c_frame");
         else begin
            e = qc.pop_front();
            chk("c_word", 32'(w_c), e.w);
            chk("c_ok", 32'(ok_c), 32'(e.ok));
            chk("c_err", 32'(er_c), 32'(!e.ok));
            chk("c_cnt", 32'(e_c), e.ec);
         end
      end
   end

   task automatic drv(int d, logic v, logic b, logic s, logic c);
      @(negedge clk);
      {v_a, in_a, s_a, c_a} = '0;
      {v_b, in_b, s_b, c_b} = '0;
      {v_c, in_c, s_c, c_c} = '0;
      if (d == 0) {v_a, in_a, s_a, c_a} = {v, b, s, c};
      if (d == 1) {v_b, in_b, s_b, c_b} = {v, b, s, c};
      if (d == 2) {v_c, in_c, s_c, c_c} = {v, b, s, c};
   endtask

   task automatic frame(int d, logic [31:0] bits, int n);
      for (int i = 0; i < n; i++) drv(d, 1'b1, bits[i], 1'b0, 1'b0);
   endtask

   initial begin
      rstn = 1'b0;
      {v_a, in_a, s_a, c_a} = '0;
      {v_b, in_b, s_b, c_b} = '0;
      {v_c, in_c, s_c, c_c} = '0;
      repeat (2) @(negedge clk);
      chk("rst_fd", 32'({fd_a, fd_b, fd_c}), 32'h0);
      chk("rst_ok_err", 32'({ok_a, er_a, ok_b, er_b, ok_c, er_c}), 32'h0);
      chk("rst_word", 32'({w_a, w_b, w_c}), 32'h0);
      chk("rst_cnt", 32'({e_a, e_b, e_c}), 32'h0);
      rstn = 1'b1;
      // 1,0,1,0,0 -> two ones, pass
      qa.push_back('{32'h05, 1'b1, 0});
      frame(0, 32'b00101, 5);
      // back-to-back: 1,1,1,0,0 fails, 0,0,0,1,1 passes
      qa.push_back('{32'h07, 1'b0, 1});
      qa.push_back('{32'h18, 1'b1, 1});
      frame(0, 32'b00111, 5);
      frame(0, 32'b11000, 5);
      // 1,0, three idle cycles, 0,1,0
      qa.push_back('{32'h09, 1'b1, 1});
      drv(0, 1, 1, 0, 0);
      drv(0, 1, 0, 0, 0);
      repeat (3) drv(0, 0, 0, 0, 0);
      drv(0, 1, 0, 0, 0);
      drv(0, 1, 1, 0, 0);
      drv(0, 1, 0, 0, 0);
      // 1,1,1 aborted by sync carrying 0, then 1,1,0,0
      qa.push_back('{32'h06, 1'b1, 1});
      drv(0, 1, 1, 0, 0);
      drv(0, 1, 1, 0, 0);
      drv(0, 1, 1, 0, 0);
      drv(0, 1, 0, 1, 0);
      frame(0, 32'b0011, 4);
      // sync on what would be the final bit discards the frame
      frame(0, 32'b1111, 4);
      drv(0, 1, 0, 1, 0);
      drv(0, 0, 0, 0, 0);
      drv(0, 1, 1, 1, 0);
      repeat (3) drv(0, 0, 0, 0, 0);
      // async reset mid-frame after 3 bits
      drv(0, 1, 1, 0, 0);
      drv(0, 1, 0, 0, 0);
      drv(0, 1, 1, 0, 0);
      #2 rstn = 1'b0;
      #1;
      chk("arst_fd", 32'(fd_a), 32'h0);
      chk("arst_ok_err", 32'({ok_a, er_a}), 32'h0);
      chk("arst_word", 32'(w_a), 32'h0);
      chk("arst_cnt", 32'(e_a), 32'h0);
      drv(0, 0, 0, 0, 0);
      rstn = 1'b1;
      qa.push_back('{32'h06, 1'b1, 0});
      frame(0, 32'b00110, 5);
      drv(0, 0, 0, 0, 0);
      // ERR_W=2: five all-ones frames saturate at 3
      for (int k = 1; k <= 5; k++) begin
         qb.push_back('{32'h1f, 1'b0, (k > 3) ? 3 : k});
         frame(1, 32'h1f, 5);
      end
      // clear on the cycle an error frame completes
      qb.push_back('{32'h1f, 1'b0, 0});
      frame(1, 32'hf, 4);
      drv(1, 1, 1, 0, 1);
      drv(1, 0, 0, 0, 0);
      // all-zeros frame fails M=2 with counter restarting at 1
      qb.push_back('{32'h00, 1'b0, 1});
      frame(1, 32'h0, 5);
      // N=8, M=4: 1,0,1,0,1,0,1,0 -> 0x55
      qc.push_back('{32'h55, 1'b1, 0});
      frame(2, 32'h55, 8);
      qc.push_back('{32'hf0, 1'b1, 0});
      frame(2, 32'hf0, 8);
      qc.push_back('{32'hf1, 1'b0, 1});
      frame(2, 32'hf1, 8);
      drv(0, 0, 0, 0, 0);
      repeat (20) @(negedge clk);
      chk("a_pending", 32'(qa.size()), 32'h0);
      chk("b_pending", 32'(qb.size()), 32'h0);
      chk("c_pending", 32'(qc.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
